cascade_counter: RTL and testbench

CASCADE_COUNTER -- requirements
Module: cascade_counter

---
 rtl/cascade_counter.sv | 124 ++++++++++++
 tb/tb_cascade_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cascade_counter.sv
// Cascade counter: NUM_STAGES chained STAGE_BITS-wide counters with
// per-stage terminal values, parallel load, clear and a full-chain wrap pulse.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   clear          synchronous zeroing of all stages
//   count_enable   advance the chain by one step
//   count_down     1 = decrement, 0 = increment (down build only)
//   load           parallel load of load_val
//   load_val       load data, stage i at [i*STAGE_BITS +: STAGE_BITS]
//   rollover_val   per-stage terminal value, same packing
//   count_out      registered stage counts, same packing
//   stage_rollover bit i = stage i at its terminal value
//   rollover_flag  all stages at their terminal value
//   wrap_pulse     registered one-cycle pulse on full-chain wrap
//
// Build option: define CASCADE_COUNTER_DOWN_EN to enable down counting.
// Without it count_down is accepted but ignored and the chain counts up only.

module cascade_counter #(
    parameter int NUM_STAGES = 3,
    parameter int STAGE_BITS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               count_enable,
    input  logic                               count_down,
    input  logic                               load,
    input  logic [NUM_STAGES*STAGE_BITS-1:0]   load_val,
    input  logic [NUM_STAGES*STAGE_BITS-1:0]   rollover_val,
    output logic [NUM_STAGES*STAGE_BITS-1:0]   count_out,
    output logic [NUM_STAGES-1:0]              stage_rollover,
    output logic                               rollover_flag,
    output logic                               wrap_pulse
);

    localparam int W = NUM_STAGES * STAGE_BITS;

    logic [W-1:0]          count_q;
    logic [W-1:0]          count_d;
    logic [W-1:0]          count_step;
    logic                  wrap_q;
    logic                  wrap_d;
    logic [NUM_STAGES-1:0] term;
    logic [NUM_STAGES-1:0] carry;

`ifdef CASCADE_COUNTER_DOWN_EN
    logic down;
    assign down = count_down;
`else
    logic unused_count_down;
    assign unused_count_down = count_down;
`endif

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        logic [STAGE_BITS-1:0] cnt;
        logic [STAGE_BITS-1:0] rv;
        logic [STAGE_BITS-1:0] nxt;

        assign cnt = count_q[g*STAGE_BITS +: STAGE_BITS];
        assign rv  = rollover_val[g*STAGE_BITS +: STAGE_BITS];

`ifdef CASCADE_COUNTER_DOWN_EN
        assign term[g] = down ? (cnt == '0) : (cnt >= rv);

        // A loaded value above the terminal snaps back to the terminal
        // when counting down, rather than walking down through it.
        always_comb begin
            nxt = cnt;
            if (down) begin
                if ((cnt == '0) || (cnt > rv)) nxt = rv;
                else                           nxt = cnt - 1'b1;
            end else begin
                if (cnt >= rv) nxt = '0;
                else           nxt = cnt + 1'b1;
            end
        end
`else
        // ">=" so that a loaded value above the terminal wraps to 0.
        assign term[g] = (cnt >= rv);
        assign nxt     = term[g] ? '0 : cnt + 1'b1;
`endif

        // Stage g steps only when every lower stage is terminal.
        if (g == 0) begin : g_first
            assign carry[g] = 1'b1;
        end else begin : g_rest
            assign carry[g] = carry[g-1] & term[g-1];
        end

        assign count_step[g*STAGE_BITS +: STAGE_BITS] = carry[g] ? nxt : cnt;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (count_enable) begin
            count_d = count_step;
            wrap_d  = &term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out      = count_q;
    assign stage_rollover = term;
    assign rollover_flag  = &term;
    assign wrap_pulse     = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter (3 stages x 4 bits).
// Vector table plus hand-written full-period and enable-toggle sequences.

module tb_cascade_counter;

    logic        clk = 1'b0;
    logic        rst, clear, count_enable, count_down, load;
    logic [11:0] load_val, rollover_val;
    logic [11:0] count_out;
    logic [2:0]  stage_rollover;
    logic        rollover_flag, wrap_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, clear, load, en, down;
        logic [11:0] lv, rv;
        logic [11:0] cnt;
        logic        wrap, flag;
        logic [2:0]  sr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    cascade_counter #(.NUM_STAGES(3), .STAGE_BITS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .count_enable(count_enable), .count_down(count_down),
        .load(load), .load_val(load_val), .rollover_val(rollover_val),
        .count_out(count_out), .stage_rollover(stage_rollover),
        .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(logic r, logic c, logic l, logic e, logic d,
                                logic [11:0] lv, logic [11:0] rv,
                                logic [11:0] cnt, logic w, logic f,
                                logic [2:0] sr);
        vec_t v;
        v.rst = r; v.clear = c; v.load = l; v.en = e; v.down = d;
        v.lv = lv; v.rv = rv; v.cnt = cnt;
        v.wrap = w; v.flag = f; v.sr = sr;
        return v;
    endfunction

    // Mixed-radix view of the chain for rollover 2/3/4 (radices 3,4,5).
    function automatic logic [11:0] enc(int v);
        logic [3:0] s2, s1, s0;
        s2 = 4'(v / 20);
        s1 = 4'((v / 5) % 4);
        s0 = 4'(v % 5);
        return {s2, s1, s0};
    endfunction

    function automatic logic [2:0] enc_sr(int v);
        return {(v / 20) >= 2, ((v / 5) % 4) >= 3, (v % 5) >= 4};
    endfunction

    task automatic cmp(string name, logic [11:0] act, logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(string name, vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; clear = v.clear; load = v.load;
        count_enable = v.en; count_down = v.down;
        load_val = v.lv; rollover_val = v.rv;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp({name, ".count"}, count_out, e.cnt);
        cmp({name, ".wrap"}, {11'd0, wrap_pulse}, {11'd0, e.wrap});
        cmp({name, ".flag"}, {11'd0, rollover_flag}, {11'd0, e.flag});
        cmp({name, ".sr"}, {9'd0, stage_rollover}, {9'd0, e.sr});
    endtask

    initial begin
        int steps;
        rst = 1'b1; clear = 1'b0; count_enable = 1'b0; count_down = 1'b0;
        load = 1'b0; load_val = '0; rollover_val = 12'h234;

        //              r  c  l  e  d  lv      rv      cnt     w  f  sr
        tbl.push_back(mk(1, 0, 1, 1, 0, 12'h103, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(1, 0, 1, 1, 0, 12'h103, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h234, 12'h001, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 1, 0, 12'h103, 12'h234, 12'h103, 0, 0, 3'b000));
        tbl.push_back(mk(0, 1, 1, 0, 0, 12'h103, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h004, 12'h234, 12'h004, 0, 0, 3'b001));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h234, 12'h010, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h00F, 12'h234, 12'h00F, 0, 0, 3'b001));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h234, 12'h010, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h234, 12'h234, 12'h234, 0, 1, 3'b111));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h234, 12'h000, 1, 0, 3'b000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 12'h000, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h234, 12'h234, 12'h234, 0, 1, 3'b111));
        tbl.push_back(mk(0, 1, 0, 1, 0, 12'h000, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h234, 12'h234, 12'h234, 0, 1, 3'b111));
        tbl.push_back(mk(0, 0, 1, 1, 0, 12'h234, 12'h234, 12'h234, 0, 1, 3'b111));
        tbl.push_back(mk(1, 1, 1, 1, 0, 12'h234, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'hFFF, 12'h234, 12'hFFF, 0, 1, 3'b111));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h234, 12'h000, 1, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 12'h001, 12'h234, 12'h001, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h001, 12'h000, 1, 0, 3'b110));
        tbl.push_back(mk(0, 0, 0, 1, 0, 12'h000, 12'h234, 12'h001, 0, 0, 3'b000));
`ifdef CASCADE_COUNTER_DOWN_EN
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h000, 12'h234, 12'h000, 0, 1, 3'b111));
        tbl.push_back(mk(0, 0, 0, 1, 1, 12'h000, 12'h234, 12'h234, 1, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 1, 12'h010, 12'h234, 12'h010, 0, 0, 3'b101));
        tbl.push_back(mk(0, 0, 0, 1, 1, 12'h000, 12'h234, 12'h004, 0, 0, 3'b110));
        tbl.push_back(mk(0, 0, 1, 0, 1, 12'h00F, 12'h234, 12'h00F, 0, 0, 3'b110));
        tbl.push_back(mk(0, 0, 0, 1, 1, 12'h000, 12'h234, 12'h004, 0, 0, 3'b110));
`else
        tbl.push_back(mk(1, 0, 0, 0, 1, 12'h000, 12'h234, 12'h000, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 12'h000, 12'h234, 12'h001, 0, 0, 3'b000));
        tbl.push_back(mk(0, 0, 1, 0, 1, 12'h00F, 12'h234, 12'h00F, 0, 0, 3'b001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 12'h000, 12'h234, 12'h010, 0, 0, 3'b000));
`endif

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // Full period: 59 steps reach 234, the 60th wraps with a pulse.
        apply("per.rst", mk(1, 0, 0, 0, 0, 12'h000, 12'h234,
                            12'h000, 0, 0, 3'b000));
        for (int k = 1; k <= 60; k++) begin
            int v;
            v = k % 60;
            apply($sformatf("per%0d", k),
                  mk(0, 0, 0, 1, 0, 12'h000, 12'h234,
                     enc(v), k == 60, v == 59, enc_sr(v)));
        end
        apply("per.after", mk(0, 0, 0, 0, 0, 12'h000, 12'h234,
                              12'h000, 0, 0, 3'b000));

        // Alternating enable: 5 steps in 10 cycles, then hold.
        apply("tog.rst", mk(1, 0, 0, 0, 0, 12'h000, 12'h234,
                            12'h000, 0, 0, 3'b000));
        steps = 0;
        for (int i = 0; i < 13; i++) begin
            logic e;
            e = (i < 10) && (i % 2 == 0);
            if (e) steps++;
            apply($sformatf("tog%0d", i),
                  mk(0, 0, 0, e, 0, 12'h000, 12'h234,
                     enc(steps), 0, steps == 59, enc_sr(steps)));
        end
        cmp("tog.final", count_out, 12'h010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
